// File: rtl/fc_pkg.sv
// fc_pkg: shared widths and FSM state encoding for the streaming fully-connected engine.
package fc_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int ACC_W_DEF = 32;
   localparam int QM_W = 16;
   localparam int QS_W = 5;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_X = 3'd1,
      BIAS   = 3'd2,
      MAC    = 3'd3,
      REQ    = 3'd4,
      OUT    = 3'd5,
      DONE   = 3'd6
   } state_t;
endpackage

// File: rtl/fc_stream_unit_if.sv
// fc_stream_unit_if: x/w/b input streams and y result stream of the FC engine.
interface fc_stream_unit_if import fc_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W = ACC_W_DEF
);
   logic x_valid, x_ready;
   logic signed [DATA_W-1:0] x_data;
   logic w_valid, w_ready;
   logic signed [DATA_W-1:0] w_data;
   logic b_valid, b_ready;
   logic signed [ACC_W-1:0] b_data;
   logic y_valid, y_ready;
   logic signed [DATA_W-1:0] y_data;
   modport master (
      output x_valid, x_data, w_valid, w_data, b_valid, b_data, y_ready,
      input  x_ready, w_ready, b_ready, y_valid, y_data
   );
   modport slave (
      input  x_valid, x_data, w_valid, w_data, b_valid, b_data, y_ready,
      output x_ready, w_ready, b_ready, y_valid, y_data
   );
endinterface

// File: rtl/fc_requant.sv
// fc_requant: multiply, round-half-up shift, zero-point add, saturate and optional ReLU.
module fc_requant import fc_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W = ACC_W_DEF
)(
   input  logic signed [ACC_W-1:0]  acc,
   input  logic signed [QM_W-1:0]   q_mult,
   input  logic [QS_W-1:0]          q_shift,
   input  logic signed [DATA_W-1:0] out_zp,
   input  logic                     relu_en,
   output logic signed [DATA_W-1:0] y
);
   localparam int PW = ACC_W + QM_W;
   localparam logic signed [PW:0] HI = (PW+1)'(2**(DATA_W-1) - 1);
   localparam logic signed [PW:0] LO = -HI - 1;
   logic signed [PW-1:0] p, rnd, r;
   logic signed [PW:0] s;
   logic signed [DATA_W-1:0] sat;
   // The product cannot reach the top bits of PW, so adding the rounding term never overflows
   always_comb begin
      p = PW'(acc) * PW'(q_mult);
      rnd = (q_shift == '0) ? '0 : PW'(1) << (q_shift - 1'b1);
      r = (p + rnd) >>> q_shift;
      s = (PW+1)'(r) + (PW+1)'(out_zp);
      sat = (s > HI) ? HI[DATA_W-1:0] : (s < LO) ? LO[DATA_W-1:0] : s[DATA_W-1:0];
      y = (relu_en && sat < out_zp) ? out_zp : sat;
   end
endmodule

// File: rtl/fc_stream_unit.sv
// fc_stream_unit: streaming quantised matrix-vector engine, y = requant(W*(x - in_zp) + b).
// Buffers one input vector, then per row takes a bias, in_size weights and emits one result.
module fc_stream_unit import fc_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int MAX_IN = 256,
   parameter int MAX_OUT = 4096
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [15:0]              in_size,
   input  logic [15:0]              out_size,
   input  logic signed [DATA_W-1:0] in_zp,
   input  logic signed [DATA_W-1:0] out_zp,
   input  logic signed [QM_W-1:0]   q_mult,
   input  logic [QS_W-1:0]          q_shift,
   input  logic                     relu_en,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   fc_stream_unit_if.slave          s
);
   localparam int AW = $clog2(MAX_IN);
   localparam int PR_W = 2*DATA_W + 1;
   state_t state;
   logic [15:0] n_in, n_out, i, j, row;
   logic signed [DATA_W-1:0] zp_in, zp_out;
   logic signed [QM_W-1:0] qm;
   logic [QS_W-1:0] qs;
   logic relu;
   logic signed [ACC_W-1:0] acc;
   logic signed [DATA_W:0] xbuf [MAX_IN];
   logic signed [DATA_W:0] xv;
   logic signed [PR_W-1:0] prod;
   logic signed [DATA_W-1:0] rq;
   logic dim_bad;

   assign dim_bad = in_size == '0 || in_size > 16'(MAX_IN) || out_size == '0 || out_size > 16'(MAX_OUT);
   assign xv = xbuf[j[AW-1:0]];
   assign prod = PR_W'(xv) * PR_W'(s.w_data);

   fc_requant #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_rq (
      .acc(acc), .q_mult(qm), .q_shift(qs), .out_zp(zp_out), .relu_en(relu), .y(rq)
   );

   // Vector buffer has no reset so it maps onto LUT RAM with asynchronous reads
   always_ff @(posedge clk)
      if (s.x_valid && s.x_ready) xbuf[i[AW-1:0]] <= (DATA_W+1)'(s.x_data) - (DATA_W+1)'(zp_in);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         {busy, done, err} <= '0;
         {s.x_ready, s.w_ready, s.b_ready, s.y_valid} <= '0;
         s.y_data <= '0;
         {i, j, row} <= '0;
         {n_in, n_out} <= '0;
         {zp_in, zp_out, qm, qs, relu} <= '0;
         acc <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               {n_in, n_out, zp_in, zp_out} <= {in_size, out_size, in_zp, out_zp};
               {qm, qs, relu} <= {q_mult, q_shift, relu_en};
               {i, row} <= '0;
               state <= dim_bad ? DONE : LOAD_X;
               busy <= !dim_bad;
               done <= dim_bad;
               err <= dim_bad;
               s.x_ready <= !dim_bad;
            end
            LOAD_X: if (s.x_valid) begin
               i <= i + 1'b1;
               if (i == n_in - 1'b1) begin
                  s.x_ready <= 1'b0;
                  s.b_ready <= 1'b1;
                  state <= BIAS;
               end
            end
            BIAS: if (s.b_valid) begin
               acc <= s.b_data;
               j <= '0;
               s.b_ready <= 1'b0;
               s.w_ready <= 1'b1;
               state <= MAC;
            end
            MAC: if (s.w_valid) begin
               acc <= acc + ACC_W'(prod);
               j <= j + 1'b1;
               if (j == n_in - 1'b1) begin
                  s.w_ready <= 1'b0;
                  state <= REQ;
               end
            end
            REQ: begin
               s.y_data <= rq;
               s.y_valid <= 1'b1;
               state <= OUT;
            end
            OUT: if (s.y_ready) begin
               s.y_valid <= 1'b0;
               row <= row + 1'b1;
               if (row == n_out - 1'b1) begin
                  busy <= 1'b0;
                  done <= 1'b1;
                  state <= DONE;
               end else begin
                  s.b_ready <= 1'b1;
                  state <= BIAS;
               end
            end
            DONE: begin
               done <= 1'b0;
               err <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
